// File: rtl/seg7_page_scheduler.sv
// Round-robin page scheduler for a shared 4-digit BCD display, with a preempting
// one-shot alert page and a sequential double-dabble binary-to-BCD converter.
module seg7_page_scheduler #(
  parameter int NUM_SRC   = 4,
  parameter int VAL_W     = 14,
  parameter int DWELL_CYC = 50000000,
  parameter int ALERT_CYC = 150000000
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM_SRC*VAL_W-1:0] src_val,
  input  logic [NUM_SRC-1:0]       src_en,
  input  logic                     alert_req,
  input  logic [1:0]               alert_src,
  output logic                     alert_ack,
  output logic [15:0]              bcd,
  output logic [1:0]               page,
  output logic                     ovf,
  output logic                     busy
);

  localparam int MAX_CYC = (ALERT_CYC > DWELL_CYC) ? ALERT_CYC : DWELL_CYC;
  localparam int CNT_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL_CYC - 1);
  localparam logic [CNT_W-1:0] ALERT_LD = CNT_W'(ALERT_CYC - 1);
  localparam logic [VAL_W-1:0] MAX_VAL  = VAL_W'(9999);
  localparam logic [1:0]       LAST_SRC = 2'(NUM_SRC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    CONV   = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t             state_r;
  logic [1:0]         page_r;
  logic [15:0]        bcd_r;
  logic               ovf_r;
  logic               busy_r;
  logic               ack_r;
  logic [CNT_W-1:0]   dwell_r;
  logic               pend_r;
  logic [1:0]         pend_src_r;
  logic [1:0]         sel_r;
  logic               sel_alert_r;
  logic               clamp_r;
  logic [13:0]        val_r;
  logic [15:0]        acc_r;
  logic [3:0]         bit_r;

  logic               rot_found_s;
  logic [1:0]         rot_idx_s;
  logic [1:0]         alert_idx_s;
  logic [1:0]         chosen_s;
  logic [VAL_W-1:0]   sel_val_s;
  logic               clamp_s;
  logic               accept_s;
  logic [15:0]        dd_s;

  // One double-dabble step: add 3 to every nibble >= 5, then shift in the next bit.
  function automatic logic [15:0] dd_step(input logic [15:0] acc, input logic b);
    logic [15:0] adj;
    for (int i = 0; i < 4; i++) begin
      adj[i*4 +: 4] = (acc[i*4 +: 4] >= 4'd5) ? acc[i*4 +: 4] + 4'd3 : acc[i*4 +: 4];
    end
    return (adj << 1) | {15'd0, b};
  endfunction

  // Rotation search: nearest enabled index after page, current page searched last.
  always_comb begin
    int idx;
    idx         = 0;
    rot_found_s = 1'b0;
    rot_idx_s   = page_r;
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx         = (int'(page_r) + k) % NUM_SRC;
      rot_found_s = rot_found_s | src_en[idx];
      rot_idx_s   = src_en[idx] ? 2'(idx) : rot_idx_s;
    end
  end

  // Source choice, value mux and clamp detection for the SELECT cycle.
  always_comb begin
    alert_idx_s = (int'(pend_src_r) < NUM_SRC) ? pend_src_r : 2'd0;
    chosen_s    = pend_r ? alert_idx_s : rot_idx_s;
    sel_val_s   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      sel_val_s = (2'(i) == chosen_s) ? src_val[i*VAL_W +: VAL_W] : sel_val_s;
    end
    clamp_s  = (sel_val_s > MAX_VAL);
    accept_s = alert_req & ~pend_r;
    dd_s     = dd_step(acc_r, val_r[13]);
  end

  // Scheduler FSM, alert latch, converter datapath and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= IDLE;
      page_r      <= LAST_SRC;
      bcd_r       <= 16'h0000;
      ovf_r       <= 1'b0;
      busy_r      <= 1'b0;
      ack_r       <= 1'b0;
      dwell_r     <= '0;
      pend_r      <= 1'b0;
      pend_src_r  <= 2'd0;
      sel_r       <= 2'd0;
      sel_alert_r <= 1'b0;
      clamp_r     <= 1'b0;
      val_r       <= 14'd0;
      acc_r       <= 16'h0000;
      bit_r       <= 4'd0;
    end else begin
      ack_r <= accept_s;
      if (accept_s) begin
        pend_r     <= 1'b1;
        pend_src_r <= alert_src;
      end

      case (state_r)
        IDLE: begin
          if (pend_r || alert_req || (|src_en)) begin
            state_r <= SELECT;
            busy_r  <= 1'b1;
          end
        end
        SELECT: begin
          if (pend_r || rot_found_s) begin
            sel_r       <= chosen_s;
            sel_alert_r <= pend_r;
            if (pend_r) begin
              pend_r <= 1'b0;
            end
            val_r   <= clamp_s ? 14'd9999 : sel_val_s[13:0];
            clamp_r <= clamp_s;
            acc_r   <= 16'h0000;
            bit_r   <= 4'd0;
            state_r <= CONV;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        CONV: begin
          acc_r <= dd_s;
          val_r <= {val_r[12:0], 1'b0};
          bit_r <= bit_r + 4'd1;
          // Publish the finished result as a single atomic update.
          if (bit_r == 4'd13) begin
            bcd_r   <= dd_s;
            page_r  <= sel_r;
            ovf_r   <= clamp_r;
            dwell_r <= sel_alert_r ? ALERT_LD : DWELL_LD;
            state_r <= HOLD;
            busy_r  <= 1'b0;
          end
        end
        HOLD: begin
          if (pend_r || (dwell_r == '0)) begin
            state_r <= SELECT;
            busy_r  <= 1'b1;
          end else begin
            dwell_r <= dwell_r - CNT_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign alert_ack = ack_r;
  assign bcd       = bcd_r;
  assign page      = page_r;
  assign ovf       = ovf_r;
  assign busy      = busy_r;

endmodule
